// File: rtl/synthesizer_channel_gate.sv
// rtl/synthesizer_channel_gate.sv - per-channel IQ gate with a frame-aligned mask swap and a frame-structure check
// Optional: SYNTH_CHANNEL_GATE_FRAME_COUNT_EN adds saturating frame and misalign counters.
package synthesizer_channel_gate_pkg;
  localparam int NUM_CHANNELS = 16;
  localparam int CHANNEL_INDEX_WIDTH = $clog2(NUM_CHANNELS);

  typedef struct packed {
    logic                           valid;
    logic                           last;
    logic [CHANNEL_INDEX_WIDTH-1:0] data_index;
  } channelizer_control_t;

  typedef struct packed {
    logic                           valid;
    logic                           last;
    logic [CHANNEL_INDEX_WIDTH-1:0] data_index;
    logic [CHANNEL_INDEX_WIDTH:0]   active_channel_count;
  } synthesizer_control_t;
endpackage

module synthesizer_channel_gate #(
  parameter int NUM_CHANNELS        = synthesizer_channel_gate_pkg::NUM_CHANNELS,
  parameter int CHANNEL_INDEX_WIDTH = $clog2(NUM_CHANNELS),
  parameter int DATA_WIDTH          = 19
) (
  input  logic                                               Clk,
  input  logic                                               Rst,
  input  logic                                               Mask_wr_valid,
  input  logic [NUM_CHANNELS-1:0]                            Mask_wr_data,
  input  synthesizer_channel_gate_pkg::channelizer_control_t Input_ctrl,
  input  logic signed [DATA_WIDTH-1:0]                       Input_data [2],
  output synthesizer_channel_gate_pkg::synthesizer_control_t Output_ctrl,
  output logic signed [DATA_WIDTH-1:0]                       Output_data [2],
  output logic                                               Mask_pending,
  output logic                                               Error_frame_misalign
`ifdef SYNTH_CHANNEL_GATE_FRAME_COUNT_EN
  ,
  output logic [31:0]                                        Frame_count,
  output logic [15:0]                                        Misalign_count
`endif
);

  localparam logic [CHANNEL_INDEX_WIDTH:0]   FULL_COUNT = (CHANNEL_INDEX_WIDTH+1)'(NUM_CHANNELS);
  localparam logic [CHANNEL_INDEX_WIDTH-1:0] LAST_IDX   = CHANNEL_INDEX_WIDTH'(NUM_CHANNELS-1);

  function automatic logic [CHANNEL_INDEX_WIDTH:0] popcount(input logic [NUM_CHANNELS-1:0] m);
    logic [CHANNEL_INDEX_WIDTH:0] c;
    c = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) c = c + (CHANNEL_INDEX_WIDTH+1)'(m[i]);
    return c;
  endfunction

  logic [NUM_CHANNELS-1:0]          active_mask_q, active_mask_d;
  logic [NUM_CHANNELS-1:0]          pending_mask_q, pending_mask_d;
  logic [CHANNEL_INDEX_WIDTH:0]     active_count_q, active_count_d;
  logic [CHANNEL_INDEX_WIDTH:0]     pending_count_q, pending_count_d;
  logic                             mask_pending_q, mask_pending_d;
  logic [CHANNEL_INDEX_WIDTH-1:0]   exp_idx_q, exp_idx_d;
  logic                             err_q, err_d;
  logic signed [DATA_WIDTH-1:0]     out_data_q [2];
  logic signed [DATA_WIDTH-1:0]     out_data_d [2];
  synthesizer_channel_gate_pkg::synthesizer_control_t out_ctrl_q, out_ctrl_d;
  logic                             swap;
  logic                             gate;

  always_comb begin
    // A write landing on the boundary cycle refills pending after the old pending mask is consumed.
    swap            = Input_ctrl.valid && Input_ctrl.last && mask_pending_q;
    active_mask_d   = swap ? pending_mask_q : active_mask_q;
    active_count_d  = swap ? pending_count_q : active_count_q;
    pending_mask_d  = pending_mask_q;
    pending_count_d = pending_count_q;
    mask_pending_d  = mask_pending_q && !swap;
    if (Mask_wr_valid) begin
      pending_mask_d  = Mask_wr_data;
      pending_count_d = popcount(Mask_wr_data);
      mask_pending_d  = 1'b1;
    end

    gate                            = active_mask_q[Input_ctrl.data_index];
    out_ctrl_d.valid                = Input_ctrl.valid;
    out_ctrl_d.last                 = Input_ctrl.last;
    out_ctrl_d.data_index           = Input_ctrl.data_index;
    out_ctrl_d.active_channel_count = active_count_q;
    out_data_d[0]                   = gate ? Input_data[0] : '0;
    out_data_d[1]                   = gate ? Input_data[1] : '0;

    err_d     = Input_ctrl.valid &&
                ((Input_ctrl.data_index != exp_idx_q) ||
                 (Input_ctrl.last != (Input_ctrl.data_index == LAST_IDX)));
    exp_idx_d = exp_idx_q;
    if (Input_ctrl.valid) exp_idx_d = Input_ctrl.last ? '0 : Input_ctrl.data_index + 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      active_mask_q   <= '1;
      pending_mask_q  <= '1;
      active_count_q  <= FULL_COUNT;
      pending_count_q <= FULL_COUNT;
      mask_pending_q  <= 1'b0;
      exp_idx_q       <= '0;
      err_q           <= 1'b0;
      out_ctrl_q      <= '0;
      out_data_q[0]   <= '0;
      out_data_q[1]   <= '0;
    end else begin
      active_mask_q   <= active_mask_d;
      pending_mask_q  <= pending_mask_d;
      active_count_q  <= active_count_d;
      pending_count_q <= pending_count_d;
      mask_pending_q  <= mask_pending_d;
      exp_idx_q       <= exp_idx_d;
      err_q           <= err_d;
      out_ctrl_q      <= out_ctrl_d;
      out_data_q[0]   <= out_data_d[0];
      out_data_q[1]   <= out_data_d[1];
    end
  end

  assign Output_ctrl          = out_ctrl_q;
  assign Output_data[0]       = out_data_q[0];
  assign Output_data[1]       = out_data_q[1];
  assign Mask_pending         = mask_pending_q;
  assign Error_frame_misalign = err_q;

`ifdef SYNTH_CHANNEL_GATE_FRAME_COUNT_EN
  logic [31:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] mis_cnt_q, mis_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    mis_cnt_d   = mis_cnt_q;
    if (Input_ctrl.valid && Input_ctrl.last && (frame_cnt_q != '1)) frame_cnt_d = frame_cnt_q + 32'd1;
    if (err_d && (mis_cnt_q != '1)) mis_cnt_d = mis_cnt_q + 16'd1;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      frame_cnt_q <= '0;
      mis_cnt_q   <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      mis_cnt_q   <= mis_cnt_d;
    end
  end

  assign Frame_count    = frame_cnt_q;
  assign Misalign_count = mis_cnt_q;
`endif

endmodule

// File: tb/tb_synthesizer_channel_gate.sv
// tb/tb_synthesizer_channel_gate.sv - scoreboard bench for synthesizer_channel_gate
module tb_synthesizer_channel_gate;
  localparam int N   = 16;
  localparam int DW  = 19;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic                          Rst;
  logic                          Mask_wr_valid;
  logic [N-1:0]                  Mask_wr_data;
  synthesizer_channel_gate_pkg::channelizer_control_t Input_ctrl;
  synthesizer_channel_gate_pkg::synthesizer_control_t Output_ctrl;
  logic signed [DW-1:0]          Input_data [2];
  logic signed [DW-1:0]          Output_data [2];
  logic                          Mask_pending;
  logic                          Error_frame_misalign;
`ifdef SYNTH_CHANNEL_GATE_FRAME_COUNT_EN
  logic [31:0]                   Frame_count;
  logic [15:0]                   Misalign_count;
`endif

  synthesizer_channel_gate dut (
    .Clk                  (Clk),
    .Rst                  (Rst),
    .Mask_wr_valid        (Mask_wr_valid),
    .Mask_wr_data         (Mask_wr_data),
    .Input_ctrl           (Input_ctrl),
    .Input_data           (Input_data),
    .Output_ctrl          (Output_ctrl),
    .Output_data          (Output_data),
    .Mask_pending         (Mask_pending),
    .Error_frame_misalign (Error_frame_misalign)
`ifdef SYNTH_CHANNEL_GATE_FRAME_COUNT_EN
    ,
    .Frame_count          (Frame_count),
    .Misalign_count       (Misalign_count)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [N-1:0] m_active, m_pending;
  int           m_active_cnt, m_pend_cnt, m_exp, m_frames, m_mis;
  bit           m_pend_flag;

  typedef logic [50:0] exp_t;
  exp_t  sb_q[$];
  string tag_q[$];

  function automatic int ones(input logic [N-1:0] m);
    int c = 0;
    for (int i = 0; i < N; i++) if (m[i]) c++;
    return c;
  endfunction

  task automatic model_reset();
    m_active = '1; m_pending = '1; m_active_cnt = N; m_pend_cnt = N;
    m_pend_flag = 0; m_exp = 0; m_frames = 0; m_mis = 0;
  endtask

  task automatic step(input string tag, input bit v, input bit l, input int idx,
                      input int i_val, input int q_val, input bit wr, input logic [N-1:0] wd);
    logic signed [DW-1:0] ei, eq;
    logic [4:0]           cnt;
    logic [3:0]           idx4;
    bit                   err;
    exp_t                 e, a;
    idx4 = idx[3:0];
    Input_ctrl.valid      = v;
    Input_ctrl.last       = l;
    Input_ctrl.data_index = idx4;
    Input_data[0]         = DW'(i_val);
    Input_data[1]         = DW'(q_val);
    Mask_wr_valid         = wr;
    Mask_wr_data          = wd;
    ei  = m_active[idx4] ? DW'(i_val) : '0;
    eq  = m_active[idx4] ? DW'(q_val) : '0;
    cnt = 5'(m_active_cnt);
    err = v && ((idx != m_exp) || (l != (idx == N-1)));
    if (v && l && m_pend_flag) begin
      m_active = m_pending; m_active_cnt = m_pend_cnt; m_pend_flag = 0;
    end
    if (wr) begin
      m_pending = wd; m_pend_cnt = ones(wd); m_pend_flag = 1;
    end
    if (v) m_exp = l ? 0 : (idx + 1) % N;
    if (v && l) m_frames++;
    if (err) m_mis++;
    e = {v, l, idx4, cnt, ei, eq, err, m_pend_flag};
    sb_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge Clk); #1;
    a = {Output_ctrl.valid, Output_ctrl.last, Output_ctrl.data_index,
         Output_ctrl.active_channel_count, Output_data[0], Output_data[1],
         Error_frame_misalign, Mask_pending};
    check_val(tag_q.pop_front(), 64'(a), 64'(sb_q.pop_front()));
  endtask

  task automatic do_reset(input string tag);
    Rst = 1'b1;
    Input_ctrl = '0; Input_data[0] = '0; Input_data[1] = '0;
    Mask_wr_valid = 1'b0; Mask_wr_data = '0;
    @(posedge Clk); #1;
    Rst = 1'b0;
    model_reset();
    check_val({tag, ".ctrl"}, 64'(Output_ctrl), 64'd0);
    check_val({tag, ".i"}, 64'(Output_data[0]), 64'd0);
    check_val({tag, ".q"}, 64'(Output_data[1]), 64'd0);
    check_val({tag, ".pend"}, 64'(Mask_pending), 64'd0);
    check_val({tag, ".err"}, 64'(Error_frame_misalign), 64'd0);
  endtask

  task automatic run_frame(input string tag, input int wa, input logic [N-1:0] da,
                           input int wb, input logic [N-1:0] db);
    for (int i = 0; i < N; i++)
      step($sformatf("%s[%0d]", tag, i), 1'b1, i == N-1, i, i + 1, -(i + 1),
           (i == wa) || (i == wb), (i == wb) ? db : da);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    Rst = 1'b1;
    Input_ctrl = '0; Input_data[0] = '0; Input_data[1] = '0;
    Mask_wr_valid = 1'b0; Mask_wr_data = '0;
    model_reset();
    @(posedge Clk); #1;
    do_reset("rst0");

    run_frame("plain", -1, '0, -1, '0);
    run_frame("wr5",    5, 16'h0005, -1, '0);
    run_frame("gate5",  3, 16'h0000, 6, 16'hFFFF);
    run_frame("full",   2, 16'h0000, -1, '0);
    run_frame("zero",  -1, '0, -1, '0);
    run_frame("wrlast", 15, 16'hAAAA, -1, '0);
    run_frame("held",  -1, '0, -1, '0);
    run_frame("aaaa",  -1, '0, -1, '0);

    step("mis0", 1'b1, 1'b0, 0, 5, -5, 1'b0, '0);
    step("mis1", 1'b1, 1'b0, 1, 6, -6, 1'b0, '0);
    step("mis3", 1'b1, 1'b0, 3, 7, -7, 1'b0, '0);
    step("mis4", 1'b1, 1'b0, 4, 8, -8, 1'b0, '0);
    step("mis7", 1'b1, 1'b1, 7, 9, -9, 1'b0, '0);
    step("idle", 1'b0, 1'b0, 0, 0, 0, 1'b0, '0);

    for (int i = 0; i <= 8; i++)
      step($sformatf("part[%0d]", i), 1'b1, 1'b0, i, i + 1, -(i + 1), i == 4, 16'h0003);
    do_reset("rst_mid");
    run_frame("post0", -1, '0, -1, '0);
    run_frame("post1", -1, '0, -1, '0);
    run_frame("post2", -1, '0, -1, '0);
    step("idle2", 1'b0, 1'b0, 0, 0, 0, 1'b0, '0);

`ifdef SYNTH_CHANNEL_GATE_FRAME_COUNT_EN
    check_val("frame_count", 64'(Frame_count), 64'(m_frames));
    check_val("misalign_count", 64'(Misalign_count), 64'(m_mis));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
